// File: rtl/i2c_responder_if.sv
// Pad-side I2C lines plus the captured register pair of the responder.
// data_valid is a one-cycle strobe with no ready: data_0/data_1 change in that cycle and hold until the next strobe.
interface i2c_responder_if;
  logic       scl;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic       data_valid;
  logic       busy;

  modport slave (
    input  scl, sda_in,
    output sda_oe, data_0, data_1, data_valid, busy
  );

  modport master (
    output scl, sda_in,
    input  sda_oe, data_0, data_1, data_valid, busy
  );
endinterface

// File: rtl/i2c_responder.sv
// Write-only I2C target: fixed address plus two data bytes, ACKed, presented as a register pair.
// Optional I2C_RESPONDER_GLITCH_FILTER_EN adds a 4-cycle stability filter on scl/sda.
module i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'b110_0110
) (
  input  logic           clk_50MHz,
  input  logic           rst_n,
  i2c_responder_if.slave bus,
  output logic [2:0]     fsm_state
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA0, DATA0_ACK, DATA1, DATA1_ACK, IGNORE
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f, scl_d, sda_d;
  logic [2:0] bit_cnt;
  logic       byte_full;
  logic [6:0] shift;
  logic [7:0] s0, s1, data_0, data_1;
  logic       data_valid, busy, sda_oe_c;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl};
      sda_sync <= {sda_sync[0], bus.sda_in};
    end
  end

`ifdef I2C_RESPONDER_GLITCH_FILTER_EN
  logic [1:0] scl_cnt, sda_cnt;

  // A new level is taken only after it has been seen on 4 consecutive cycles.
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= 2'd0;
      sda_cnt <= 2'd0;
    end else begin
      if (scl_sync[1] == scl_f) scl_cnt <= 2'd0;
      else if (scl_cnt == 2'd3) begin
        scl_f   <= scl_sync[1];
        scl_cnt <= 2'd0;
      end else scl_cnt <= scl_cnt + 2'd1;
      if (sda_sync[1] == sda_f) sda_cnt <= 2'd0;
      else if (sda_cnt == 2'd3) begin
        sda_f   <= sda_sync[1];
        sda_cnt <= 2'd0;
      end else sda_cnt <= sda_cnt + 2'd1;
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  // START/STOP need scl stable high, so an sda change under a moving scl is never one.
  logic scl_rise, scl_fall, scl_high, start_c, stop_c, data_state, addr_ok;
  logic [7:0] byte_nxt;
  assign scl_rise   = scl_f & ~scl_d;
  assign scl_fall   = ~scl_f & scl_d;
  assign scl_high   = scl_f & scl_d;
  assign start_c    = scl_high & sda_d & ~sda_f;
  assign stop_c     = scl_high & ~sda_d & sda_f;
  assign byte_nxt   = {shift, sda_f};
  assign addr_ok    = (byte_nxt[7:1] == DEV_ADDR) && !byte_nxt[0];
  assign data_state = (state == ADDR) || (state == DATA0) || (state == DATA1);

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_c)     state_nxt = ADDR;
    else if (stop_c) state_nxt = IDLE;
    else begin
      case (state)
        ADDR: begin
          if (scl_rise && !byte_full && bit_cnt == 3'd7 && !addr_ok) state_nxt = IGNORE;
          else if (byte_full && scl_fall)                            state_nxt = ADDR_ACK;
        end
        ADDR_ACK:  if (scl_fall)              state_nxt = DATA0;
        DATA0:     if (byte_full && scl_fall) state_nxt = DATA0_ACK;
        DATA0_ACK: if (scl_fall)              state_nxt = DATA1;
        DATA1:     if (byte_full && scl_fall) state_nxt = DATA1_ACK;
        DATA1_ACK: if (scl_fall)              state_nxt = IGNORE;
        default:   state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sda_oe_c = 1'b0;
    case (state)
      ADDR_ACK, DATA0_ACK, DATA1_ACK: sda_oe_c = 1'b1;
      default:                        sda_oe_c = 1'b0;
    endcase
  end

  // byte_full marks "8 bits taken, waiting for the falling edge that opens the ACK slot".
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 3'd0;
      byte_full  <= 1'b0;
      shift      <= 7'd0;
      s0         <= 8'h00;
      s1         <= 8'h00;
      data_0     <= 8'h00;
      data_1     <= 8'h00;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (start_c) begin
        bit_cnt   <= 3'd0;
        byte_full <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_c) begin
        bit_cnt   <= 3'd0;
        byte_full <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (data_state && scl_rise && !byte_full) begin
          shift   <= byte_nxt[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            byte_full <= 1'b1;
            if (state == ADDR && !addr_ok) busy <= 1'b0;
            if (state == DATA0) s0 <= byte_nxt;
            if (state == DATA1) s1 <= byte_nxt;
          end
        end
        if (scl_fall && byte_full) byte_full <= 1'b0;
        if (state == DATA1_ACK && scl_fall) begin
          data_0     <= s0;
          data_1     <= s1;
          data_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.sda_oe     = sda_oe_c;
  assign bus.data_0     = data_0;
  assign bus.data_1     = data_1;
  assign bus.data_valid = data_valid;
  assign bus.busy       = busy;
  assign fsm_state      = state;
endmodule

// File: tb/tb_i2c_responder.sv
// Bench for i2c_responder: bit-banged I2C master, transaction-level model with per-cycle output checks.
module tb_i2c_responder;
  localparam logic [6:0] DEV_ADDR = 7'b110_0110;
`ifdef I2C_RESPONDER_GLITCH_FILTER_EN
  localparam int LAT = 7;
  localparam int GLITCH_BIT = 4;
`else
  localparam int LAT = 3;
  localparam int GLITCH_BIT = -1;
`endif
  localparam int K_OE = 0, K_BUSY = 1, K_DATA = 2;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_IGNORE = 3'd7;

  logic clk, rst_n, scl_m, sda_m;
  logic [2:0] fsm_state;
  i2c_responder_if bus_if();

  assign bus_if.scl    = scl_m;
  assign bus_if.sda_in = sda_m & ~bus_if.sda_oe;

  i2c_responder #(.DEV_ADDR(DEV_ADDR)) dut (
    .clk_50MHz (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t         ev_q[$];
  ev_t         ev_c;
  logic [15:0] exp_q[$];
  logic        exp_oe, exp_busy, exp_valid, chk_en;
  logic [7:0]  exp_d0, exp_d1, m_s0;
  int          phase;
  int          n_checks = 0, n_fail = 0, n_valid = 0;
  int          tlow, thigh, v0;
  logic        a0, a1, a2, a3;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic post(input int kind, input logic [15:0] val);
    ev_t e;
    e.at   = cyc + LAT;
    e.kind = kind;
    e.val  = val;
    ev_q.push_back(e);
  endtask

  task automatic model_reset();
    ev_q.delete();
    exp_q.delete();
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
    exp_d0   = 8'h00;
    exp_d1   = 8'h00;
    phase    = 3;
  endtask

  // scoreboard: apply due model events, then compare every output
  always @(negedge clk) begin
    if (chk_en) begin
      exp_valid = 1'b0;
      while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
        ev_c = ev_q.pop_front();
        case (ev_c.kind)
          K_OE:    exp_oe = ev_c.val[0];
          K_BUSY:  exp_busy = ev_c.val[0];
          default: begin
            exp_d0    = ev_c.val[15:8];
            exp_d1    = ev_c.val[7:0];
            exp_valid = 1'b1;
          end
        endcase
      end
      check("sda_oe", bus_if.sda_oe, exp_oe);
      check("busy", bus_if.busy, exp_busy);
      check("data_0", bus_if.data_0, exp_d0);
      check("data_1", bus_if.data_1, exp_d1);
      check("data_valid", bus_if.data_valid, exp_valid);
      if (bus_if.data_valid) begin
        n_valid++;
        if (exp_q.size() == 0) check("sb_unexpected_valid", 16'd1, 16'd0);
        else check("sb_pair", {bus_if.data_0, bus_if.data_1}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_low(input logic b, input bit glitch);
    wait_cyc(tlow / 2);
    sda_m = b;
    if (glitch) begin
      wait_cyc(3);
      scl_m = 1'b1;
      wait_cyc(2);
      scl_m = 1'b0;
      wait_cyc(tlow - tlow / 2 - 5);
    end else begin
      wait_cyc(tlow - tlow / 2);
    end
  endtask

  task automatic do_start();
    sda_m = 1'b1;
    wait_cyc(tlow / 2);
    scl_m = 1'b1;
    wait_cyc(thigh / 2);
    sda_m = 1'b0;
    post(K_BUSY, 16'd1);
    phase = 0;
    wait_cyc(thigh - thigh / 2);
    scl_m = 1'b0;
  endtask

  task automatic do_stop();
    wait_cyc(tlow / 2);
    sda_m = 1'b0;
    wait_cyc(tlow - tlow / 2);
    scl_m = 1'b1;
    wait_cyc(thigh / 2);
    sda_m = 1'b1;
    post(K_BUSY, 16'd0);
    phase = 3;
    wait_cyc(thigh);
  endtask

  // phase: 0 expects address, 1 first data byte, 2 second data byte, 3 nothing more accepted
  task automatic send_byte(input logic [7:0] b, input int glitch_bit, input bit abort_in_ack,
                           output logic ack);
    logic accept;
    accept = (phase == 0) ? (b == {DEV_ADDR, 1'b0}) : (phase == 1 || phase == 2);
    for (int i = 7; i >= 0; i--) begin
      drive_low(b[i], i == glitch_bit);
      scl_m = 1'b1;
      if (i == 0 && phase == 0 && !accept) post(K_BUSY, 16'd0);
      wait_cyc(thigh);
      scl_m = 1'b0;
      if (i == 0 && accept) post(K_OE, 16'd1);
    end
    if (abort_in_ack) begin
      wait_cyc(tlow / 2);
      sda_m = 1'b1;
      wait_cyc(2);
      ack = bus_if.sda_in;
    end else begin
      drive_low(1'b1, 1'b0);
      scl_m = 1'b1;
      ack = bus_if.sda_in;
      check("ack_slot", ack, !accept);
      wait_cyc(thigh);
      scl_m = 1'b0;
      if (accept) post(K_OE, 16'd0);
      case (phase)
        0: phase = accept ? 1 : 3;
        1: begin
          m_s0  = b;
          phase = 2;
        end
        2: begin
          post(K_DATA, {m_s0, b});
          exp_q.push_back({m_s0, b});
          phase = 3;
        end
        default: phase = 3;
      endcase
    end
  endtask

  initial begin
    int nb, ending, nk;
    logic [7:0] addr;
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    chk_en = 1'b0;
    tlow = 62;
    thigh = 63;
    model_reset();
    wait_cyc(5);
    check("rst_sda_oe", bus_if.sda_oe, 1'b0);
    check("rst_data_0", bus_if.data_0, 8'h00);
    check("rst_data_1", bus_if.data_1, 8'h00);
    check("rst_data_valid", bus_if.data_valid, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_state", fsm_state, ST_IDLE);
    rst_n = 1'b1;
    wait_cyc(2);
    chk_en = 1'b1;

    // full write at 400 kHz
    v0 = n_valid;
    do_start();
    send_byte(8'hCC, -1, 1'b0, a0);
    send_byte(8'h11, -1, 1'b0, a1);
    send_byte(8'h33, -1, 1'b0, a2);
    do_stop();
    check("t1_acks", {a0, a1, a2}, 3'b000);
    check("t1_data_0", bus_if.data_0, 8'h11);
    check("t1_data_1", bus_if.data_1, 8'h33);
    check("t1_valid_count", n_valid - v0, 1);
    check("t1_busy", bus_if.busy, 1'b0);

    // address mismatch
    v0 = n_valid;
    do_start();
    send_byte(8'hCE, -1, 1'b0, a0);
    send_byte(8'h5A, -1, 1'b0, a1);
    do_stop();
    check("t2_acks", {a0, a1}, 2'b11);
    check("t2_data_0", bus_if.data_0, 8'h11);
    check("t2_valid_count", n_valid - v0, 0);

    // read request is refused
    do_start();
    send_byte(8'hCD, -1, 1'b0, a0);
    wait_cyc(LAT + 2);
    check("t3_ack", a0, 1'b1);
    check("t3_state", fsm_state, ST_IGNORE);
    check("t3_busy", bus_if.busy, 1'b0);
    do_stop();

    // one data byte then STOP
    v0 = n_valid;
    do_start();
    send_byte(8'hCC, -1, 1'b0, a0);
    send_byte(8'h55, -1, 1'b0, a1);
    do_stop();
    check("t4_acks", {a0, a1}, 2'b00);
    check("t4_valid_count", n_valid - v0, 0);
    check("t4_data", {bus_if.data_0, bus_if.data_1}, 16'h1133);

    // repeated START, then a third byte
    v0 = n_valid;
    do_start();
    send_byte(8'hCC, -1, 1'b0, a0);
    send_byte(8'hAA, -1, 1'b0, a1);
    do_start();
    send_byte(8'hCC, -1, 1'b0, a0);
    send_byte(8'h01, -1, 1'b0, a1);
    send_byte(8'h02, -1, 1'b0, a2);
    send_byte(8'h03, -1, 1'b0, a3);
    do_stop();
    check("t5_acks", {a0, a1, a2, a3}, 4'b0001);
    check("t5_data", {bus_if.data_0, bus_if.data_1}, 16'h0102);
    check("t5_valid_count", n_valid - v0, 1);

    // reset during the first data byte's ACK
    do_start();
    send_byte(8'hCC, -1, 1'b0, a0);
    send_byte(8'h77, -1, 1'b1, a1);
    check("t6_oe_before_reset", bus_if.sda_oe, 1'b1);
    check("t6_sda_held_low", a1, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_oe_async_release", bus_if.sda_oe, 1'b0);
    wait_cyc(2);
    scl_m = 1'b1;
    wait_cyc(5);
    check("t6_data_in_reset", {bus_if.data_0, bus_if.data_1}, 16'h0000);
    rst_n = 1'b1;
    wait_cyc(5);
    v0 = n_valid;
    do_start();
    send_byte(8'hCC, -1, 1'b0, a0);
    send_byte(8'h11, GLITCH_BIT, 1'b0, a1);
    send_byte(8'h33, -1, 1'b0, a2);
    do_stop();
    check("t6_acks", {a0, a1, a2}, 3'b000);
    check("t6_data", {bus_if.data_0, bus_if.data_1}, 16'h1133);
    check("t6_valid_count", n_valid - v0, 1);

    // randomized transactions at varying bus speeds
    for (int t = 0; t < 20; t++) begin
      tlow   = $urandom_range(20, 40);
      thigh  = $urandom_range(20, 40);
      addr   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'hCC;
      nb     = $urandom_range(0, 3);
      ending = (t == 19) ? 0 : $urandom_range(0, 2);
      do_start();
      send_byte(addr, -1, 1'b0, a0);
      for (int k = 0; k < nb; k++) send_byte(8'($urandom_range(0, 255)), -1, 1'b0, a1);
      if (ending == 1) begin
        nk = $urandom_range(1, 6);
        for (int k = 0; k < nk; k++) begin
          drive_low(1'($urandom_range(0, 1)), 1'b0);
          scl_m = 1'b1;
          wait_cyc(thigh);
          scl_m = 1'b0;
        end
      end
      if (ending != 2) do_stop();
    end

    wait_cyc(LAT + 5);
    check("sb_leftover", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
